seg_scan_capture: RTL

//  Receive end of the 6-digit multiplexed 7-segment display bus (seg/dig) driven by the scan driver.

---
 rtl/seg_scan_capture.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_capture.sv
// Receive-side monitor for a 6-digit multiplexed 7-segment bus.
// Debounces each scan phase, decodes it back to a symbol, and publishes complete frames.

module seg_scan_slot (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_wr,
    input  logic       i_commit,
    input  logic [3:0] i_sym,
    input  logic       i_dp,
    input  logic       i_err,
    output logic [3:0] o_sym,
    output logic       o_dp,
    output logic       o_err
);
    logic [3:0] r_sh_sym;
    logic       r_sh_dp;
    logic       r_sh_err;
    logic [3:0] r_sym;
    logic       r_dp;
    logic       r_err;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_sh_sym <= 4'h0;
            r_sh_dp  <= 1'b0;
            r_sh_err <= 1'b0;
            r_sym    <= 4'hF;
            r_dp     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (i_wr) begin
                r_sh_sym <= i_sym;
                r_sh_dp  <= i_dp;
                r_sh_err <= i_err;
            end
            if (i_commit) begin
                r_sym <= r_sh_sym;
                r_dp  <= r_sh_dp;
                r_err <= r_sh_err;
            end
        end
    end

    assign o_sym = r_sym;
    assign o_dp  = r_dp;
    assign o_err = r_err;
endmodule

module seg_scan_capture #(
    parameter int STABLE_CYC  = 1000,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic [7:0]  i_seg,
    input  logic [5:0]  i_dig,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic [5:0]  o_seg_err,
    output logic        o_frame_valid,
    output logic        o_stalled
);
    localparam int          NPOS     = 6;
    localparam logic [15:0] CNT_LAST = 16'(STABLE_CYC - 1);
    localparam logic [19:0] TMO_LIM  = 20'(TIMEOUT_CYC);

    typedef enum logic {ST_SETTLE, ST_SAMPLED} state_t;
    state_t r_state, w_state_nxt;

    logic [7:0]  r_seg, r_seg_prev;
    logic [5:0]  r_dig, r_dig_prev;
    logic [15:0] r_stable_cnt;
    logic [19:0] r_tmo_cnt;
    logic [5:0]  r_seen;
    logic        r_frame_valid;

    logic        w_same, w_dig_ok, w_sample, w_commit, w_err;
    logic [5:0]  w_sel, w_wr;
    logic [3:0]  w_sym;

    assign w_same   = ({r_seg, r_dig} == {r_seg_prev, r_dig_prev});
    assign w_sel    = ~r_dig;
    assign w_dig_ok = (w_sel != 6'd0) && ((w_sel & (w_sel - 6'd1)) == 6'd0);
    assign w_commit = (r_seen == 6'h3F);

    // DP does not take part in decode; 06 is always 1, there is no D glyph.
    always_comb begin
        w_sym = 4'hF;
        w_err = 1'b0;
        case (r_seg[6:0])
            7'h3F: w_sym = 4'h0;
            7'h06: w_sym = 4'h1;
            7'h5B: w_sym = 4'h2;
            7'h4F: w_sym = 4'h3;
            7'h66: w_sym = 4'h4;
            7'h6D: w_sym = 4'h5;
            7'h7D: w_sym = 4'h6;
            7'h07: w_sym = 4'h7;
            7'h7F: w_sym = 4'h8;
            7'h6F: w_sym = 4'h9;
            7'h77: w_sym = 4'hA;
            7'h7C: w_sym = 4'hB;
            7'h3E: w_sym = 4'hC;
            7'h37: w_sym = 4'hE;
            7'h00: w_sym = 4'hF;
            default: begin
                w_sym = 4'hF;
                w_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        case (r_state)
            ST_SETTLE: begin
                if (w_same && (r_stable_cnt == CNT_LAST) && w_dig_ok) begin
                    w_sample    = 1'b1;
                    w_state_nxt = ST_SAMPLED;
                end
            end
            ST_SAMPLED: begin
                if (!w_same) w_state_nxt = ST_SETTLE;
            end
            default: w_state_nxt = ST_SETTLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state       <= ST_SETTLE;
            r_seg         <= 8'h00;
            r_dig         <= 6'h00;
            r_seg_prev    <= 8'h00;
            r_dig_prev    <= 6'h00;
            r_stable_cnt  <= 16'd0;
            r_tmo_cnt     <= 20'd0;
            r_seen        <= 6'd0;
            r_frame_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_seg      <= i_seg;
            r_dig      <= i_dig;
            r_seg_prev <= r_seg;
            r_dig_prev <= r_dig;
            if (!w_same)
                r_stable_cnt <= 16'd0;
            else if (r_stable_cnt != 16'hFFFF)
                r_stable_cnt <= r_stable_cnt + 16'd1;
            if (w_sample)
                r_tmo_cnt <= 20'd0;
            else if (r_tmo_cnt != 20'hFFFFF)
                r_tmo_cnt <= r_tmo_cnt + 20'd1;
            // A sample can never land on a commit cycle, but OR it in so it is never lost.
            r_seen        <= (w_commit ? 6'd0 : r_seen) | w_wr;
            r_frame_valid <= w_commit;
        end
    end

    for (genvar p = 0; p < NPOS; p++) begin : g_pos
        assign w_wr[p] = w_sample & w_sel[NPOS-1-p];
        seg_scan_slot u_slot (
            .i_clk    (i_clk),
            .i_clr    (i_clr),
            .i_wr     (w_wr[p]),
            .i_commit (w_commit),
            .i_sym    (w_sym),
            .i_dp     (r_seg[7]),
            .i_err    (w_err),
            .o_sym    (o_digits[4*p +: 4]),
            .o_dp     (o_dp[p]),
            .o_err    (o_seg_err[p])
        );
    end

    assign o_frame_valid = r_frame_valid;
    assign o_stalled     = (r_tmo_cnt >= TMO_LIM);
endmodule
